// File: rtl/raster_engine.sv
// rtl/raster_engine.sv - command-driven triangle rasterizer with clear, clip and write stall
module raster_engine #(
    parameter int RENDERING_WIDTH  = 320,
    parameter int RENDERING_HEIGHT = 240,
    parameter int COORD_WIDTH      = 11,
    parameter int COLOR_WIDTH      = 3,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                       aClock,
    input  logic                       aReset,
    input  logic                       aCommandValid,
    output logic                       anOutCommandReady,
    input  logic [1:0]                 aCommandOp,
    input  logic [COLOR_WIDTH-1:0]     aCommandColor,
    input  logic [6*COORD_WIDTH-1:0]   aCommandVertices,
    output logic [ADDR_WIDTH-1:0]      anOutPixelAddr,
    output logic [COLOR_WIDTH-1:0]     anOutPixelData,
    output logic                       anOutPixelWrite,
    input  logic                       aPixelReady,
    output logic                       anOutFrameDone,
    input  logic                       aFrameFlipped
);

    localparam int CW = COORD_WIDTH;
    // Edge values need two (CW+1)-bit signed products plus one bit for their difference.
    localparam int EW = 2 * COORD_WIDTH + 3;

    localparam logic [CW-1:0]         X_LAST    = CW'(RENDERING_WIDTH - 1);
    localparam logic [CW-1:0]         Y_LAST    = CW'(RENDERING_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RENDERING_WIDTH * RENDERING_HEIGHT - 1);

    localparam logic [1:0] OP_CLEAR     = 2'd1;
    localparam logic [1:0] OP_TRIANGLE  = 2'd2;
    localparam logic [1:0] OP_END_FRAME = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RASTER,
        S_CLEAR,
        S_FRAME_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           vx_q [3];
    logic [CW-1:0]           vy_q [3];
    logic [COLOR_WIDTH-1:0]  color_q;
    logic [CW-1:0]           cur_x_q, cur_x_d;
    logic [CW-1:0]           cur_y_q, cur_y_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [COLOR_WIDTH-1:0]  data_q, data_d;
    logic                    ready_q;
    logic                    done_q;

    logic                    accept;
    logic                    latch_cmd;
    logic                    stall;
    logic [CW-1:0]           min_x, max_x, min_y, max_y;
    logic [CW-1:0]           clip_max_x, clip_max_y;
    logic signed [EW-1:0]    area;
    logic                    skip;
    logic [CW-1:0]           cand_x, cand_y;
    logic signed [EW-1:0]    e0, e1, e2;
    logic                    cand_inside;
    logic [ADDR_WIDTH-1:0]   cand_addr;
    logic                    last_col, last_row;

    function automatic logic signed [EW-1:0] ext(input logic [CW-1:0] v);
        return $signed({{(EW - CW){1'b0}}, v});
    endfunction

    // Signed edge function of point p against directed edge a->b.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [CW-1:0] ax, input logic [CW-1:0] ay,
        input logic [CW-1:0] bx, input logic [CW-1:0] by,
        input logic [CW-1:0] px, input logic [CW-1:0] py
    );
        logic signed [EW-1:0] dxb, dyb, dxp, dyp;
        dxb = ext(bx) - ext(ax);
        dyb = ext(by) - ext(ay);
        dxp = ext(px) - ext(ax);
        dyp = ext(py) - ext(ay);
        return dxb * dyp - dyb * dxp;
    endfunction

    assign accept = aCommandValid & ready_q & (state_q == S_IDLE);
    // A pending write that the framebuffer refuses freezes the whole pipeline.
    assign stall  = write_q & ~aPixelReady;

    // Bounding box, screen clip and degenerate test from the latched vertices.
    always_comb begin
        min_x = vx_q[0];
        max_x = vx_q[0];
        min_y = vy_q[0];
        max_y = vy_q[0];
        for (int i = 1; i < 3; i++) begin
            if (vx_q[i] < min_x) min_x = vx_q[i];
            if (vx_q[i] > max_x) max_x = vx_q[i];
            if (vy_q[i] < min_y) min_y = vy_q[i];
            if (vy_q[i] > max_y) max_y = vy_q[i];
        end
        clip_max_x = (max_x > X_LAST) ? X_LAST : max_x;
        clip_max_y = (max_y > Y_LAST) ? Y_LAST : max_y;
        area       = edge_fn(vx_q[0], vy_q[0], vx_q[1], vy_q[1], vx_q[2], vy_q[2]);
        skip       = (min_x > X_LAST) | (min_y > Y_LAST) | (area == '0);
    end

    // Next candidate pixel and its coverage; outputs are registered from this.
    always_comb begin
        last_col = (cur_x_q == clip_max_x);
        last_row = (cur_y_q == clip_max_y);
        if (state_q == S_SETUP) begin
            cand_x = min_x;
            cand_y = min_y;
        end else if (last_col) begin
            cand_x = min_x;
            cand_y = cur_y_q + CW'(1);
        end else begin
            cand_x = cur_x_q + CW'(1);
            cand_y = cur_y_q;
        end
        e0 = edge_fn(vx_q[0], vy_q[0], vx_q[1], vy_q[1], cand_x, cand_y);
        e1 = edge_fn(vx_q[1], vy_q[1], vx_q[2], vy_q[2], cand_x, cand_y);
        e2 = edge_fn(vx_q[2], vy_q[2], vx_q[0], vy_q[0], cand_x, cand_y);
        // Inclusive edges, either winding: all non-negative or all non-positive.
        cand_inside = (~e0[EW-1] & ~e1[EW-1] & ~e2[EW-1]) |
                      ((e0[EW-1] | (e0 == '0)) & (e1[EW-1] | (e1 == '0)) & (e2[EW-1] | (e2 == '0)));
        cand_addr = ADDR_WIDTH'(cand_y) * ADDR_WIDTH'(RENDERING_WIDTH) + ADDR_WIDTH'(cand_x);
    end

    // Next-state and next-output logic of the command FSM.
    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        write_d   = write_q;
        addr_d    = addr_q;
        data_d    = data_q;
        latch_cmd = 1'b0;
        case (state_q)
            S_IDLE: begin
                write_d = 1'b0;
                if (accept) begin
                    case (aCommandOp)
                        OP_CLEAR: begin
                            state_d   = S_CLEAR;
                            latch_cmd = 1'b1;
                            write_d   = 1'b1;
                            addr_d    = '0;
                            data_d    = aCommandColor;
                        end
                        OP_TRIANGLE: begin
                            state_d   = S_SETUP;
                            latch_cmd = 1'b1;
                        end
                        OP_END_FRAME: state_d = S_FRAME_DONE;
                        default:      state_d = S_IDLE;
                    endcase
                end
            end
            S_SETUP: begin
                if (skip) begin
                    state_d = S_IDLE;
                    write_d = 1'b0;
                end else begin
                    state_d = S_RASTER;
                    cur_x_d = cand_x;
                    cur_y_d = cand_y;
                    write_d = cand_inside;
                    addr_d  = cand_addr;
                    data_d  = color_q;
                end
            end
            S_RASTER: begin
                if (!stall) begin
                    if (last_col && last_row) begin
                        state_d = S_IDLE;
                        write_d = 1'b0;
                    end else begin
                        cur_x_d = cand_x;
                        cur_y_d = cand_y;
                        write_d = cand_inside;
                        addr_d  = cand_addr;
                    end
                end
            end
            S_CLEAR: begin
                if (!stall) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                        write_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FRAME_DONE: begin
                write_d = 1'b0;
                if (aFrameFlipped) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    // State, latched command and registered outputs.
    always_ff @(posedge aClock) begin
        if (aReset) begin
            state_q <= S_IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            color_q <= '0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_d == S_FRAME_DONE);
            if (latch_cmd) begin
                color_q <= aCommandColor;
                for (int i = 0; i < 3; i++) begin
                    vx_q[i] <= aCommandVertices[(2 * i) * CW +: CW];
                    vy_q[i] <= aCommandVertices[(2 * i + 1) * CW +: CW];
                end
            end
        end
    end

    assign anOutCommandReady = ready_q;
    assign anOutPixelAddr    = addr_q;
    assign anOutPixelData    = data_q;
    assign anOutPixelWrite   = write_q;
    assign anOutFrameDone    = done_q;

endmodule

// File: tb/tb_raster_engine.sv
// tb/tb_raster_engine.sv - randomized self-checking bench for raster_engine
module tb_raster_engine;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int CW  = 11;
    localparam int CLW = 3;
    localparam int AW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [CLW-1:0]  cmd_color;
    logic [6*CW-1:0] cmd_verts;
    logic [AW-1:0]   pix_addr;
    logic [CLW-1:0]  pix_data;
    logic            pix_write;
    logic            pix_ready;
    logic            frame_done;
    logic            flip;

    always #5 clk = ~clk;

    raster_engine #(
        .RENDERING_WIDTH(W), .RENDERING_HEIGHT(H), .COORD_WIDTH(CW),
        .COLOR_WIDTH(CLW), .ADDR_WIDTH(AW)
    ) dut (
        .aClock(clk), .aReset(rst),
        .aCommandValid(cmd_valid), .anOutCommandReady(cmd_ready),
        .aCommandOp(cmd_op), .aCommandColor(cmd_color), .aCommandVertices(cmd_verts),
        .anOutPixelAddr(pix_addr), .anOutPixelData(pix_data), .anOutPixelWrite(pix_write),
        .aPixelReady(pix_ready), .anOutFrameDone(frame_done), .aFrameFlipped(flip)
    );

    int total = 0;
    int bad   = 0;
    int stall_mode = 0;
    int got_addr[$];
    int got_data[$];
    int exp_addr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Framebuffer side: drive aPixelReady, collect accepted writes, check holds while stalled.
    logic            prev_stall = 1'b0;
    logic [AW-1:0]   prev_addr;
    logic [CLW-1:0]  prev_data;
    always @(negedge clk) begin
        case (stall_mode)
            1:       pix_ready = ~pix_ready;
            2:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b1;
        endcase
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_write", 64'(pix_write), 64'd1);
                check("stall_hold_addr", 64'(pix_addr), 64'(prev_addr));
                check("stall_hold_data", 64'(pix_data), 64'(prev_data));
            end
            prev_stall = pix_write && !pix_ready;
            prev_addr  = pix_addr;
            prev_data  = pix_data;
            if (pix_write && pix_ready) begin
                got_addr.push_back(int'(pix_addr));
                got_data.push_back(int'(pix_data));
            end
        end
    end

    function automatic int edgef(int ax, int ay, int bx, int by, int px, int py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic int min3(int a, int b, int c);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Reference: fill exp_addr with covered screen pixels in row-major order, return ready latency.
    function automatic int model_tri(int x0, int y0, int x1, int y1, int x2, int y2);
        int area, mnx, mny, mxx, mxy, e0, e1, e2;
        exp_addr.delete();
        area = edgef(x0, y0, x1, y1, x2, y2);
        mnx = min3(x0, x1, x2);
        mny = min3(y0, y1, y2);
        mxx = max3(x0, x1, x2);
        mxy = max3(y0, y1, y2);
        if (area == 0 || mnx > W - 1 || mny > H - 1) return 2;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e0 = edgef(x0, y0, x1, y1, x, y);
                e1 = edgef(x1, y1, x2, y2, x, y);
                e2 = edgef(x2, y2, x0, y0, x, y);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                    exp_addr.push_back(x + y * W);
            end
        if (mxx > W - 1) mxx = W - 1;
        if (mxy > H - 1) mxy = H - 1;
        return (mxx - mnx + 1) * (mxy - mny + 1) + 2;
    endfunction

    function automatic logic [6*CW-1:0] pack(int x0, int y0, int x1, int y1, int x2, int y2);
        return {CW'(y2), CW'(x2), CW'(y1), CW'(x1), CW'(y0), CW'(x0)};
    endfunction

    task automatic send(input logic [1:0] op, input int col, input logic [6*CW-1:0] v);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_color = CLW'(col);
        cmd_verts = v;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 64'd0, 64'd1);
        else @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cmd_ready && lat < 5000);
        if (!cmd_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_writes(input string tag, input int col);
        check({tag, "_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(got_data[i]), 64'(col));
        end
    endtask

    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int col, input int mode);
        int exp_lat, lat;
        exp_lat = model_tri(x0, y0, x1, y1, x2, y2);
        got_addr.delete();
        got_data.delete();
        stall_mode = mode;
        send(2'd2, col, pack(x0, y0, x1, y1, x2, y2));
        wait_ready(lat);
        stall_mode = 0;
        if (mode == 0) check("tri_latency", 64'(lat), 64'(exp_lat));
        compare_writes("tri", col);
    endtask

    task automatic run_clear(input int col);
        int lat;
        exp_addr.delete();
        for (int i = 0; i < W * H; i++) exp_addr.push_back(i);
        got_addr.delete();
        got_data.delete();
        send(2'd1, col, '0);
        wait_ready(lat);
        check("clear_latency", 64'(lat), 64'(W * H + 1));
        compare_writes("clear", col);
    endtask

    initial begin
        int cnt, wc, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_color = '0; cmd_verts = '0;
        flip = 1'b0; pix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_write", 64'(pix_write), 64'd0);
        check("rst_addr", 64'(pix_addr), 64'd0);
        check("rst_data", 64'(pix_data), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_ready), 64'd1);

        run_clear(5);
        run_tri(1, 1, 3, 1, 1, 3, 2, 0);
        run_tri(1, 1, 1, 3, 3, 1, 2, 0);
        run_tri(1, 1, 3, 1, 1, 3, 2, 1);
        run_tri(6, 6, 12, 6, 6, 12, 4, 0);
        run_tri(20, 20, 25, 20, 20, 25, 7, 0);
        run_tri(0, 0, 2, 2, 4, 4, 1, 0);
        run_tri(0, 0, 7, 0, 0, 7, 6, 2);

        // End of frame: done held with ready low until a flip is sampled.
        send(2'd3, 0, '0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done && !cmd_ready) cnt++;
        end
        check("fd_hold_cycles", 64'(cnt), 64'd10);
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        check("flip_done", 64'(frame_done), 64'd0);
        check("flip_ready", 64'(cmd_ready), 64'd1);
        flip = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready && !frame_done) cnt++;
        end
        flip = 1'b0;
        check("idle_flip_ignored", 64'(cnt), 64'd3);
        run_clear(3);

        // Reset in the middle of a clear.
        send(2'd1, 6, '0);
        wc = 0;
        n = 0;
        while (wc < 5 && n < 200) begin
            @(negedge clk);
            if (pix_write) wc++;
            n++;
        end
        check("mid_rst_reached", 64'(wc), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_write", 64'(pix_write), 64'd0);
        check("mid_rst_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        run_tri(1, 1, 3, 1, 1, 3, 2, 0);

        for (int k = 0; k < 40; k++) begin
            run_tri(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_engine.md
# raster_engine

Parametrised command-driven rasterizer and the next generation of the Illusion render core. It accepts CLEAR, TRIANGLE and END_FRAME commands over a valid/ready handshake. Per accepted triangle it performs setup: bounding box, screen clip and degenerate rejection. It then scans the box and emits framebuffer pixel writes with backpressure. It sits between the command processor and framebuffer memory, and adds per-triangle colour, clipping, either-winding coverage and a write stall that the first-generation core lacks.

## Interface
- RENDERING_WIDTH, 320, framebuffer width in pixels
- RENDERING_HEIGHT, 240, framebuffer height in pixels
- COORD_WIDTH, 11, unsigned vertex coordinate width
- COLOR_WIDTH, 3, pixel data width
- ADDR_WIDTH, 32, pixel address width
- Clock and reset (already decided): one clock `aClock`; reset `aReset` is synchronous and active-high.
- aClock  in  1  clock
- aReset  in  1  synchronous active-high reset
- aCommandValid  in  1  command present
- anOutCommandReady  out  1  command accepted when high together with valid
- aCommandOp  in  2  0 NOP, 1 CLEAR, 2 TRIANGLE, 3 END_FRAME
- aCommandColor  in  COLOR_WIDTH  clear/triangle colour
- aCommandVertices  in  6*COORD_WIDTH  {y2,x2,y1,x1,y0,x0}, x0 in LSBs
- anOutPixelAddr  out  ADDR_WIDTH  x + y*RENDERING_WIDTH
- anOutPixelData  out  COLOR_WIDTH  pixel colour
- anOutPixelWrite  out  1  write valid
- aPixelReady  in  1  framebuffer accepts write this cycle
- anOutFrameDone  out  1  frame complete, held until flip
- aFrameFlipped  in  1  display has consumed frame

## Operation
- States:
  - IDLE: ready=1.
  - SETUP.
  - RASTER.
  - CLEAR.
  - FRAME_DONE.
- IDLE transitions on accept (valid & ready):
  - NOP → stay.
  - CLEAR → CLEAR.
  - TRIANGLE → SETUP; vertices and colour are latched.
  - END_FRAME → FRAME_DONE.
- SETUP (1 cycle): minX/maxX/minY/maxY over the three vertices; max clipped to RENDERING_WIDTH-1 / RENDERING_HEIGHT-1.
  - Skip (→ IDLE, no writes) if minX > RENDERING_WIDTH-1, minY > RENDERING_HEIGHT-1, or doubled area == 0.
  - Otherwise cursor = (minX, minY) → RASTER.
- Edge function:
  - E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
  - Signed, width 2*COORD_WIDTH+3; no overflow permitted.
- Coverage rule:
  - Pixel is inside if all three E ≥ 0 or all three ≤ 0.
  - Edges are inclusive; either winding is accepted.
- RASTER:
  - One candidate per cycle in row-major order, x fastest.
  - Inside → anOutPixelWrite=1 with triangle colour.
  - Outside → no write, cursor advances.
  - After (maxX, maxY) → IDLE.
- CLEAR: writes every address 0 .. W*H-1 in order, with the latched colour, then → IDLE.
- FRAME_DONE: anOutFrameDone=1, ready=0; a sampled aFrameFlipped → IDLE.
- aFrameFlipped outside FRAME_DONE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - anOutCommandReady=0 during the reset cycle, 1 the cycle after.
  - anOutPixelWrite=0, anOutPixelAddr=0, anOutPixelData=0, anOutFrameDone=0.
- Outputs are registered.
- TRIANGLE accepted at cycle t:
  - SETUP at t+1.
  - First candidate at t+2.
  - With no stalls, the last candidate is at t+1+N, where N is the clipped box area.
  - Ready again at t+2+N.
  - Skipped triangle: ready at t+2.
- CLEAR accepted at t: writes at t+1 .. t+W*H without stalls; ready at t+W*H+1.
- Stall: while anOutPixelWrite=1 and aPixelReady=0:
  - addr, data and write are held unchanged.
  - The cursor does not advance.
  - No write is lost or duplicated.
- Outside candidates never stall.
- END_FRAME accepted at t:
  - anOutFrameDone=1 from t+1.
  - aFrameFlipped high at cycle f (f ≥ t+1) → done=0 and ready=1 at f+1.
- Reset mid-operation (RASTER/CLEAR/FRAME_DONE):
  - Next cycle: IDLE, write=0, done=0.
  - The partial frame is abandoned.
- Coordinates ≥ the screen size inside the box are never written.
- Address arithmetic uses at least ADDR_WIDTH bits.

## Test plan
- W=4, H=3: reset, CLEAR colour 5, aPixelReady=1 → 12 consecutive writes at addr 0..11, data 5; ready high 13 cycles after accept.
- W=H=8: TRIANGLE (1,1),(3,1),(1,3), colour 2 → exactly 6 writes at addrs 9,10,11,17,18,25; 9 candidate cycles.
  - Same triangle with reversed winding → identical writes.
- Repeat the previous triangle with aPixelReady low on alternate cycles → same 6 addresses in order, no duplicates; addr/data stable while stalled.
- W=H=8, TRIANGLE (6,6),(12,6),(6,12) → writes at 54,55,62,63 only.
  - (20,20),(25,20),(20,25) → zero writes, ready 2 cycles after accept.
  - Collinear (0,0),(2,2),(4,4) → zero writes.
- END_FRAME:
  - Done=1, and ready=0 for 10 cycles.
  - Flip pulse → done=0 next cycle; next CLEAR accepted.
  - Flip asserted in IDLE → ignored.
- Assert aReset during the 5th CLEAR write → write=0 next cycle, ready=1 following cycle, subsequent TRIANGLE renders correctly.
